// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM state encoding and requester identity.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

    typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the requester not granted last wins.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic    cpu_req,
    input  logic    dbg_req,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        grant_valid = cpu_req | dbg_req;
        grant_id    = REQ_CPU;
        if (cpu_req && dbg_req) begin
            grant_id = (last_grant == REQ_CPU) ? REQ_DBG : REQ_CPU;
        end else if (dbg_req) begin
            grant_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the board's asynchronous SRAM: grants one port, runs a
// fixed-length strobe cycle, and returns read data with a one-cycle ack pulse.
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output arb_state_t        arb_state
);

    // Handshake: a requester raises req with we/addr/wdata stable and holds it until it
    // sees ack high for one cycle; ack marks completion and, for reads, valid rdata.

    arb_state_t        state;
    req_id_t           grant;
    req_id_t           last_grant;
    req_id_t           grant_id;
    logic              grant_valid;
    logic              lat_we;
    logic [2:0]        wait_cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign arb_state = state;

    rr_pick2 u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (grant_id == REQ_DBG) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
    end

    // Strobes are flopped rather than decoded so the async SRAM never sees a glitch
    // when state and latched we change on the same edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            grant        <= REQ_CPU;
            last_grant   <= REQ_DBG;
            lat_we       <= 1'b0;
            wait_cnt     <= 3'd0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wdata_oe <= 1'b0;
            Mem_CE       <= 1'b1;
            Mem_UB       <= 1'b1;
            Mem_LB       <= 1'b1;
            Mem_OE       <= 1'b1;
            Mem_WE       <= 1'b1;
            cpu_ack      <= 1'b0;
            dbg_ack      <= 1'b0;
            cpu_rdata    <= '0;
            dbg_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state        <= ACCESS;
                        grant        <= grant_id;
                        last_grant   <= grant_id;
                        lat_we       <= sel_we;
                        wait_cnt     <= 3'(WAIT_CYCLES);
                        mem_addr     <= sel_addr;
                        mem_wdata    <= sel_we ? sel_wdata : '0;
                        mem_wdata_oe <= sel_we;
                        Mem_CE       <= 1'b0;
                        Mem_UB       <= 1'b0;
                        Mem_LB       <= 1'b0;
                        Mem_OE       <= sel_we;
                        Mem_WE       <= ~sel_we;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= DONE;
                        Mem_CE  <= 1'b1;
                        Mem_UB  <= 1'b1;
                        Mem_LB  <= 1'b1;
                        Mem_OE  <= 1'b1;
                        Mem_WE  <= 1'b1;
                        cpu_ack <= (grant == REQ_CPU);
                        dbg_ack <= (grant == REQ_DBG);
                        if (!lat_we) begin
                            if (grant == REQ_CPU) cpu_rdata <= mem_rdata;
                            else                  dbg_rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    cpu_ack      <= 1'b0;
                    dbg_ack      <= 1'b0;
                    lat_we       <= 1'b0;
                    mem_wdata_oe <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: default-wait instance on a small SRAM model,
// plus a zero-wait instance for the short-cycle case.
module tb_sram_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        Reset;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    // Default instance (WAIT_CYCLES = 1)
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [19:0] cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_ack, dbg_ack;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_wdata_oe;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    arb_state_t  arb_state;

    // Zero-wait instance
    logic        w0_cpu_req;
    logic [19:0] w0_cpu_addr;
    logic        w0_cpu_ack, w0_dbg_ack;
    logic [15:0] w0_cpu_rdata, w0_dbg_rdata;
    logic [19:0] w0_mem_addr;
    logic [15:0] w0_mem_wdata, w0_mem_rdata;
    logic        w0_mem_wdata_oe;
    logic        w0_CE, w0_UB, w0_LB, w0_OE, w0_WE;
    arb_state_t  w0_state;

    // SRAM model: combinational read, write on any edge where the write strobe is active
    logic [15:0] mem [0:255];
    logic        mem_load;
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_load) mem[8'h10] <= 16'h1234;
        else if (!Mem_CE && !Mem_WE && mem_wdata_oe) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // Zero-wait SRAM model returns 0xA000 | low address bits
    assign w0_mem_rdata = 16'hA000 | {4'h0, w0_mem_addr[11:0]};

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(1)) dut (
        .Clk(clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
        .mem_rdata(mem_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .arb_state(arb_state)
    );

    sram_port_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
        .Clk(clk), .Reset(Reset),
        .cpu_req(w0_cpu_req), .cpu_we(1'b0), .cpu_addr(w0_cpu_addr), .cpu_wdata(16'h0),
        .cpu_ack(w0_cpu_ack), .cpu_rdata(w0_cpu_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(20'h0), .dbg_wdata(16'h0),
        .dbg_ack(w0_dbg_ack), .dbg_rdata(w0_dbg_rdata),
        .mem_addr(w0_mem_addr), .mem_wdata(w0_mem_wdata), .mem_wdata_oe(w0_mem_wdata_oe),
        .mem_rdata(w0_mem_rdata),
        .Mem_CE(w0_CE), .Mem_UB(w0_UB), .Mem_LB(w0_LB), .Mem_OE(w0_OE), .Mem_WE(w0_WE),
        .arb_state(w0_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with a CPU request held high alongside: reset must win.
    task automatic test_reset();
        logic [4:0] strobes;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        Reset = 1'b1; mem_load = 1'b1;
        tick(); tick();
        strobes = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
        n_cmp++; if (strobes !== 5'b11111) begin n_fail++; $display("FAIL reset_strobes: got %b want 11111", strobes); end
        n_cmp++; if (arb_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", arb_state); end
        n_cmp++; if ({mem_wdata_oe, mem_addr, mem_wdata} !== 37'h0) begin n_fail++; $display("FAIL reset_mem_out: got oe=%b addr=%h wdata=%h want 0", mem_wdata_oe, mem_addr, mem_wdata); end
        n_cmp++; if ({cpu_ack, dbg_ack, cpu_rdata, dbg_rdata} !== 34'h0) begin n_fail++; $display("FAIL reset_acks: got %b%b %h %h want 0", cpu_ack, dbg_ack, cpu_rdata, dbg_rdata); end
        cpu_req = 1'b0; mem_load = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_cpu_read();
        logic [4:0] strobes;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        tick(); // cycle 1
        strobes = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
        n_cmp++; if (strobes !== 5'b00001) begin n_fail++; $display("FAIL rd_c1_strobes: got %b want 00001", strobes); end
        n_cmp++; if (mem_addr !== 20'h00010 || mem_wdata_oe !== 1'b0) begin n_fail++; $display("FAIL rd_c1_addr: got %h oe=%b want 00010 oe=0", mem_addr, mem_wdata_oe); end
        tick(); // cycle 2
        strobes = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
        n_cmp++; if (strobes !== 5'b00001 || cpu_ack !== 1'b0) begin n_fail++; $display("FAIL rd_c2: got strobes=%b ack=%b want 00001 ack=0", strobes, cpu_ack); end
        tick(); // cycle 3: DONE
        strobes = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
        n_cmp++; if (cpu_ack !== 1'b1 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack: got cpu=%b dbg=%b want 1 0", cpu_ack, dbg_ack); end
        n_cmp++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h want 1234", cpu_rdata); end
        n_cmp++; if (strobes !== 5'b11111 || mem_addr !== 20'h00010) begin n_fail++; $display("FAIL rd_done: got strobes=%b addr=%h want 11111 00010", strobes, mem_addr); end
        tick(); // cycle 4
        cpu_req = 1'b0;
        n_cmp++; if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0 || arb_state !== IDLE) begin n_fail++; $display("FAIL rd_after: got ack=%b%b state=%0d want 00 IDLE", cpu_ack, dbg_ack, arb_state); end
        n_cmp++; if (cpu_rdata !== 16'h1234 || mem_addr !== 20'h0) begin n_fail++; $display("FAIL rd_hold: got rdata=%h addr=%h want 1234 0", cpu_rdata, mem_addr); end
        tick();
    endtask

    task automatic test_dbg_write();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 20'h00005; dbg_wdata = 16'hBEEF;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_cmp++; if ({Mem_CE, Mem_OE, Mem_WE, mem_wdata_oe} !== 4'b0101) begin n_fail++; $display("FAIL wr_c%0d_strobes: got CE,OE,WE,oe=%b want 0101", c, {Mem_CE, Mem_OE, Mem_WE, mem_wdata_oe}); end
            n_cmp++; if (mem_wdata !== 16'hBEEF || mem_addr !== 20'h00005) begin n_fail++; $display("FAIL wr_c%0d_bus: got %h@%h want BEEF@00005", c, mem_wdata, mem_addr); end
        end
        tick(); // cycle 3: DONE
        n_cmp++; if ({Mem_WE, mem_wdata_oe, dbg_ack, cpu_ack} !== 4'b1110) begin n_fail++; $display("FAIL wr_done: got WE,oe,dbg,cpu=%b want 1110", {Mem_WE, mem_wdata_oe, dbg_ack, cpu_ack}); end
        n_cmp++; if (mem_addr !== 20'h00005 || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL wr_hold: got %h@%h want BEEF@00005", mem_wdata, mem_addr); end
        tick(); // cycle 4
        dbg_req = 1'b0; dbg_we = 1'b0;
        n_cmp++; if (mem_wdata_oe !== 1'b0 || dbg_ack !== 1'b0) begin n_fail++; $display("FAIL wr_after: got oe=%b ack=%b want 0 0", mem_wdata_oe, dbg_ack); end
        n_cmp++; if (mem[5] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem: got %h want BEEF", mem[5]); end
        tick();
    endtask

    // Both requesters held high from reset: acks alternate CPU,DBG,... every 4 cycles.
    task automatic test_round_robin();
        logic [1:0] exp_ack;
        Reset = 1'b1; tick(); Reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h00005;
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_ack = 2'b00;
            if (c % 4 == 3) exp_ack = ((c / 4) % 2 == 0) ? 2'b10 : 2'b01;
            n_cmp++; if ({cpu_ack, dbg_ack} !== exp_ack) begin n_fail++; $display("FAIL rr_c%0d: got cpu,dbg=%b want %b", c, {cpu_ack, dbg_ack}, exp_ack); end
        end
        n_cmp++; if (cpu_rdata !== 16'h1234 || dbg_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rr_data: got %h %h want 1234 BEEF", cpu_rdata, dbg_rdata); end
        cpu_req = 1'b0; dbg_req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
    endtask

    task automatic test_reset_mid_write();
        logic [4:0] strobes;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00007; cpu_wdata = 16'hAAAA;
        tick(); // cycle 1
        tick(); // cycle 2: second ACCESS cycle
        n_cmp++; if (Mem_WE !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre: got WE=%b want 0", Mem_WE); end
        Reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        tick(); // cycle 3
        Reset = 1'b0;
        strobes = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};
        n_cmp++; if (strobes !== 5'b11111 || mem_wdata_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobes: got %b oe=%b want 11111 0", strobes, mem_wdata_oe); end
        n_cmp++; if (arb_state !== IDLE || mem_addr !== 20'h0) begin n_fail++; $display("FAIL rst_mid_state: got %0d addr=%h want IDLE 0", arb_state, mem_addr); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if ({cpu_ack, dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_noack%0d: got %b want 00", c, {cpu_ack, dbg_ack}); end
        end
    endtask

    // Zero-wait instance: one ACCESS cycle, ack in cycle 2, reads every 3 cycles.
    task automatic test_back_to_back();
        logic [15:0] exp_rd;
        w0_cpu_req = 1'b1; w0_cpu_addr = 20'h00010;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c % 3 == 1) begin
                n_cmp++; if (w0_OE !== 1'b0 || w0_state !== ACCESS) begin n_fail++; $display("FAIL w0_c%0d_access: got OE=%b state=%0d want 0 ACCESS", c, w0_OE, w0_state); end
            end else if (c % 3 == 2) begin
                exp_rd = 16'hA010 + 16'((c / 3) * 16);
                n_cmp++; if (w0_cpu_ack !== 1'b1 || w0_OE !== 1'b1) begin n_fail++; $display("FAIL w0_c%0d_ack: got ack=%b OE=%b want 1 1", c, w0_cpu_ack, w0_OE); end
                n_cmp++; if (w0_cpu_rdata !== exp_rd) begin n_fail++; $display("FAIL w0_c%0d_data: got %h want %h", c, w0_cpu_rdata, exp_rd); end
            end else begin
                w0_cpu_addr = w0_cpu_addr + 20'h10;
                if (c == 9) w0_cpu_req = 1'b0;
                n_cmp++; if ({w0_cpu_ack, w0_dbg_ack} !== 2'b00) begin n_fail++; $display("FAIL w0_c%0d_idle: got %b want 00", c, {w0_cpu_ack, w0_dbg_ack}); end
            end
        end
        tick();
        n_cmp++; if (w0_state !== IDLE) begin n_fail++; $display("FAIL w0_end_state: got %0d want IDLE", w0_state); end
    endtask

    initial begin
        Reset = 1'b1; mem_load = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        w0_cpu_req = 1'b0; w0_cpu_addr = '0;
        #1;
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_round_robin();
        test_reset_mid_write();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the board's single asynchronous SRAM port between two requesters: the LC-3 CPU datapath/control unit (port `cpu_`) and the debug/memory-loader path (port `dbg_`). It grants one requester at a time and sequences a fixed-length read or write cycle on the active-low SRAM strobes. It returns read data through a registered handshake. It sits between the CPU/debug logic and the top-level SRAM pins and replaces the hard-wired strobe ties.

## Interface
Parameters:
- `ADDR_W`, 20, SRAM word-address width.
- `DATA_W`, 16, SRAM data width.
- `WAIT_CYCLES`, 1, extra strobe-active cycles beyond the first; the legal range is 0..7.

Ports:
- `Clk`  in  1  sole clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `cpu_req`  in  1  CPU access request, level-held until ack.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W  CPU address; stable while `cpu_req` is high.
- `cpu_wdata`  in  DATA_W  CPU write data; stable while `cpu_req` is high.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data, valid in the `cpu_ack` cycle and held until the next CPU read completes.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: same as the CPU port, for the debug requester.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  DATA_W  data to the SRAM tristate.
- `mem_wdata_oe`  out  1  tristate enable for `mem_wdata`.
- `mem_rdata`  in  DATA_W  SRAM data bus (input side).
- `Mem_CE`, `Mem_UB`, `Mem_LB`, `Mem_OE`, `Mem_WE`  out  1 each  SRAM strobes, active-low.

## Operation
- FSM states:
  - `IDLE`: all strobes high. A grant occurs at any edge where at least one request is high; the FSM goes to `ACCESS` and latches the granted requester's `we` and `addr` into internal registers.
  - `ACCESS`: lasts WAIT_CYCLES+1 cycles, counted by a 3-bit down counter. Strobes are driven as listed below. On its last edge, reads capture `mem_rdata` into the granted requester's rdata register. Then go to `DONE`.
  - `DONE`: one cycle. All strobes high. The granted requester's ack is high. `mem_wdata_oe` stays high if the access was a write. Always go to `IDLE`.
- Arbitration:
  - A lone request is always granted.
  - When both requests are high in `IDLE`, the requester not granted most recently wins (round-robin).
  - `last_grant` updates on each grant.
- Strobes in `ACCESS`:
  - `Mem_CE`, `Mem_UB` and `Mem_LB` are 0.
  - Reads: `Mem_OE` = 0, `Mem_WE` = 1, `mem_wdata_oe` = 0.
  - Writes: `Mem_WE` = 0, `Mem_OE` = 1, `mem_wdata_oe` = 1, `mem_wdata` = the granted requester's wdata.
- `mem_addr` drives the latched address in `ACCESS` and `DONE`, and 0 in `IDLE`.
- All SRAM outputs and acks decode only from registered state (state, grant, latched `we`/`addr`). There is no combinational path from any `*_req` input to any output.
- The non-granted requester's inputs are ignored. Its request stays pending and is considered at the next `IDLE`.
- A requester drops `req` in the cycle after it samples ack. A `req` still high at the `IDLE` edge after `DONE` is treated as a new request.

## Timing
- Reset values:
  - State `IDLE`.
  - `Mem_CE`, `Mem_UB`, `Mem_LB`, `Mem_OE`, `Mem_WE` = 1.
  - `mem_wdata_oe` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `cpu_ack` = `dbg_ack` = 0; `cpu_rdata` = `dbg_rdata` = 0.
  - `last_grant` = DBG, so the CPU wins the first tie.
- Latency: request sampled at edge 0 → `ACCESS` for cycles 1..WAIT_CYCLES+1 → ack in cycle WAIT_CYCLES+2. With the default this is ack in cycle 3.
- Minimum access period is WAIT_CYCLES+3 cycles, since `IDLE` is always entered for at least one cycle.
- Writes: `Mem_WE` rises on entry to `DONE` while data and address remain driven, giving one cycle of hold.
- Reset asserted mid-access: the next edge forces the reset values. The in-flight write is aborted and the SRAM contents at that address are undefined. No ack is issued for the aborted access.
- A request and reset asserted in the same cycle: reset wins and the request is not granted.

## Structure
- Package `mem_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t`
  - `typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t`
- Sub-module `rr_pick2`: combinational two-way round-robin picker. Inputs: the two requests and `last_grant`. Outputs: `grant_valid` and `grant_id`. The FSM, counter and data registers live in `sram_port_arbiter`.

## Test plan
- Reset, then CPU read of 0x00010 with `mem_rdata` model returning 0x1234 → `Mem_OE` low for cycles 1–2, `cpu_ack` in cycle 3, `cpu_rdata` = 0x1234, `dbg_ack` never pulses.
- DBG write 0xBEEF to 0x00005 → `Mem_WE` low for 2 cycles and high in `DONE`; `mem_wdata_oe` high for 3 cycles; memory model holds 0xBEEF.
- Both requests high from reset, each re-requesting after its ack → grants alternate CPU, DBG, CPU, DBG; each access is 4 cycles apart.
- Reset pulsed during the second `ACCESS` cycle of a write → next cycle all strobes high, `mem_wdata_oe` = 0, no ack.
- WAIT_CYCLES = 0 instance: CPU read → single `ACCESS` cycle, ack in cycle 2; back-to-back reads complete every 3 cycles.
